// File: rtl/pll_bringup_seq_pkg.sv
// Shared definitions for the PLL bring-up sequencer: state encoding,
// debug/counter widths and a helper that sizes the shared timer.
package pll_bringup_seq_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_RST_HOLD  = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } pll_state_t;

    // One timer serves every timed state, so it must hold the largest
    // terminal count; a single bit is kept even when every count is 1.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pll_bringup_seq_if.sv
// Bundle between the sequencer and the user/PLL side. The master side is
// the sequencer: it reads the enable request and raw PLL lock, and drives
// the PLL controls plus the status seen by user logic.
interface pll_bringup_seq_if;
    import pll_bringup_seq_pkg::*;

    logic                enable;
    logic                pll_lock;
    logic                pll_en;
    logic                pll_resetn;
    logic                clkout_en;
    logic                ready;
    logic                fault;
    logic [RETRY_W-1:0]  retry_cnt;
    logic [LOSS_W-1:0]   loss_cnt;
    logic [STATE_W-1:0]  state;

    modport master (
        input  enable, pll_lock,
        output pll_en, pll_resetn, clkout_en, ready, fault,
               retry_cnt, loss_cnt, state
    );

    modport slave (
        output enable, pll_lock,
        input  pll_en, pll_resetn, clkout_en, ready, fault,
               retry_cnt, loss_cnt, state
    );

endinterface

// File: rtl/pll_bringup_seq_lock_filter.sv
// Brings the asynchronous PLL lock into the oscillator domain and debounces
// it: lock_f only follows the synchronized level after LOCK_FILTER
// consecutive samples of the new value, so short lock glitches are ignored.
module pll_lock_filter #(
    parameter int LOCK_FILTER = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic pll_lock,
    output logic lock_f
);

    localparam int CNT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_FILTER - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] agree_cnt;

    // Two-flop synchronizer followed by a run-length debounce on its output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            agree_cnt <= '0;
            lock_f    <= 1'b0;
        end else begin
            sync_1 <= pll_lock;
            sync_2 <= sync_1;
            if (sync_2 != lock_f) begin
                if (agree_cnt == CNT_LAST) begin
                    lock_f    <= sync_2;
                    agree_cnt <= '0;
                end else begin
                    agree_cnt <= agree_cnt + CNT_W'(1);
                end
            end else begin
                agree_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/pll_bringup_seq.sv
// Power-up/relock sequencer for the PLL. Walks pll_en / pll_resetn /
// clkout_en through reset hold, lock wait and settle, retries on lock
// timeout, restarts on lock loss and reports ready/fault. Every output is
// registered and decoded from the next state so it changes with the state.
module pll_bringup_seq
    import pll_bringup_seq_pkg::*;
#(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int SETTLE_CYCLES = 256,
    parameter int LOCK_FILTER   = 4,
    parameter int MAX_RETRIES   = 3
) (
    input  logic              clk,
    input  logic              resetn,
    pll_bringup_seq_if.master bus
);

    localparam int TIMER_W = timer_width(RESET_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
    localparam logic [TIMER_W-1:0] RESET_LAST   = TIMER_W'(RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
    localparam logic [LOSS_W-1:0]  LOSS_MAX     = '1;

    pll_state_t          state_q;
    pll_state_t          next_state;
    logic [TIMER_W-1:0]  timer_q;
    logic [RETRY_W-1:0]  retry_cnt_q;
    logic [RETRY_W-1:0]  retry_next;
    logic [LOSS_W-1:0]   loss_cnt_q;
    logic                retry_hit;
    logic                loss_hit;
    logic                lock_f;
    logic                pll_en_q;
    logic                pll_resetn_q;
    logic                clkout_en_q;
    logic                ready_q;
    logic                fault_q;

    pll_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .clk      (clk),
        .resetn   (resetn),
        .pll_lock (bus.pll_lock),
        .lock_f   (lock_f)
    );

    assign retry_next = retry_cnt_q + RETRY_W'(1);

    // Next-state selection; dropping enable beats every other transition.
    always_comb begin
        next_state = state_q;
        retry_hit  = 1'b0;
        loss_hit   = 1'b0;
        if (state_q != ST_IDLE && !bus.enable) begin
            next_state = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.enable) next_state = ST_RST_HOLD;
                end
                ST_RST_HOLD: begin
                    if (timer_q == RESET_LAST) next_state = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_f) begin
                        next_state = ST_SETTLE;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        retry_hit  = 1'b1;
                        next_state = (retry_next == RETRY_LIMIT) ? ST_FAULT : ST_RST_HOLD;
                    end
                end
                ST_SETTLE: begin
                    if (!lock_f) begin
                        next_state = ST_RST_HOLD;
                    end else if (timer_q == SETTLE_LAST) begin
                        next_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!lock_f) begin
                        loss_hit   = 1'b1;
                        next_state = ST_RST_HOLD;
                    end
                end
                ST_FAULT: begin
                    next_state = ST_FAULT;
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // State, shared timer, counters and output decode, all on one clock edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            retry_cnt_q  <= '0;
            loss_cnt_q   <= '0;
            pll_en_q     <= 1'b0;
            pll_resetn_q <= 1'b0;
            clkout_en_q  <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q <= next_state;

            if (next_state != state_q) begin
                timer_q <= '0;
            end else if (state_q == ST_RST_HOLD || state_q == ST_WAIT_LOCK ||
                         state_q == ST_SETTLE) begin
                timer_q <= timer_q + TIMER_W'(1);
            end

            if (retry_hit) begin
                retry_cnt_q <= retry_next;
            end else if ((state_q == ST_IDLE && next_state == ST_RST_HOLD) ||
                         (state_q != ST_RUN && next_state == ST_RUN)) begin
                retry_cnt_q <= '0;
            end

            if (loss_hit && loss_cnt_q != LOSS_MAX) begin
                loss_cnt_q <= loss_cnt_q + LOSS_W'(1);
            end

            pll_en_q     <= (next_state == ST_RST_HOLD) || (next_state == ST_WAIT_LOCK) ||
                            (next_state == ST_SETTLE)   || (next_state == ST_RUN);
            pll_resetn_q <= (next_state == ST_WAIT_LOCK) || (next_state == ST_SETTLE) ||
                            (next_state == ST_RUN);
            clkout_en_q  <= (next_state == ST_RUN);
            ready_q      <= (next_state == ST_RUN);
            fault_q      <= (next_state == ST_FAULT);
        end
    end

    assign bus.pll_en     = pll_en_q;
    assign bus.pll_resetn = pll_resetn_q;
    assign bus.clkout_en  = clkout_en_q;
    assign bus.ready      = ready_q;
    assign bus.fault      = fault_q;
    assign bus.retry_cnt  = retry_cnt_q;
    assign bus.loss_cnt   = loss_cnt_q;
    assign bus.state      = state_q;

    // The output clock must never be enabled while the PLL is off or in reset.
    clkout_safe_a: assert property (
        @(posedge clk) disable iff (!resetn)
        clkout_en_q |-> (pll_en_q && pll_resetn_q)
    );

endmodule

// File: tb/tb_pll_bringup_seq.sv
// Directed bench for the PLL bring-up sequencer with small parameters:
// nominal lock, lock timeout into fault, lock glitch filtering, enable
// aborts, async reset in RUN and loss counter saturation.
module tb_pll_bringup_seq;

    logic clk;
    logic resetn;
    int   check_count;
    int   error_count;
    int   inv_errors;
    int   res_low;

    pll_bringup_seq_if bus();

    pll_bringup_seq #(
        .RESET_CYCLES  (4),
        .LOCK_TIMEOUT  (32),
        .SETTLE_CYCLES (8),
        .LOCK_FILTER   (3),
        .MAX_RETRIES   (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // 10 ns oscillator clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case some wait never returns.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Watch the clock-enable safety rule on every cycle.
    always @(negedge clk) begin
        if (resetn && bus.clkout_en && (!bus.pll_en || !bus.pll_resetn))
            inv_errors++;
    end

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic wait_ready(input logic level, input int budget, input string tag);
        int n;
        n = 0;
        while (bus.ready !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, 32'(bus.ready), 32'(level));
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
        int n;
        n = 0;
        while (bus.state !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, 32'(bus.state), 32'(target));
    endtask

    task automatic check_all_off(input string tag);
        check_output(tag, 32'({bus.state, bus.pll_en, bus.pll_resetn, bus.clkout_en,
                               bus.ready, bus.fault}), 32'd0);
    endtask

    initial begin
        int errs_before;
        check_count  = 0;
        error_count  = 0;
        inv_errors   = 0;
        resetn       = 1'b0;
        bus.enable   = 1'b0;
        bus.pll_lock = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_off("rst_outs");
        check_output("rst_cnts", 32'({bus.retry_cnt, bus.loss_cnt}), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal bring-up: reset hold is exactly 4 cycles
        bus.enable = 1'b1;
        res_low = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.pll_en && !bus.pll_resetn) res_low++;
        end
        check_output("nom_reset_len", 32'(res_low), 32'd4);
        check_output("nom_wait_lock", 32'(bus.state), 32'd2);
        check_output("nom_resetn_hi", 32'(bus.pll_resetn), 32'd1);
        repeat (4) @(negedge clk);
        bus.pll_lock = 1'b1;
        // lock_f after 5 edges, SETTLE on the 6th
        repeat (6) @(negedge clk);
        check_output("nom_settle", 32'(bus.state), 32'd3);
        repeat (7) @(negedge clk);
        check_output("nom_ready_early", 32'(bus.ready), 32'd0);
        @(negedge clk);
        check_output("nom_ready", 32'({bus.ready, bus.clkout_en}), 32'd3);
        check_output("nom_run", 32'(bus.state), 32'd4);

        // Glitch of 2 cycles is filtered out
        repeat (3) @(negedge clk);
        bus.pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        bus.pll_lock = 1'b1;
        repeat (10) @(negedge clk);
        check_output("glitch2_ready", 32'(bus.ready), 32'd1);
        check_output("glitch2_loss", 32'(bus.loss_cnt), 32'd0);

        // Glitch of 3 cycles is accepted as a lock loss
        bus.pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        bus.pll_lock = 1'b1;
        repeat (2) @(negedge clk);
        check_output("glitch3_hold", 32'(bus.ready), 32'd1);
        @(negedge clk);
        check_output("glitch3_drop", 32'({bus.ready, bus.clkout_en}), 32'd0);
        check_output("glitch3_state", 32'(bus.state), 32'd1);
        check_output("glitch3_loss", 32'(bus.loss_cnt), 32'd1);
        wait_ready(1'b1, 60, "glitch3_relock");
        check_output("glitch3_run", 32'(bus.state), 32'd4);

        // Async reset in the middle of a RUN cycle
        repeat (2) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_all_off("areset_outs");
        check_output("areset_loss", 32'(bus.loss_cnt), 32'd0);
        bus.enable = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Abort during SETTLE
        bus.enable = 1'b1;
        wait_state(3'd3, 40, "abort_settle_reach");
        bus.enable = 1'b0;
        @(negedge clk);
        check_all_off("abort_settle");

        // Abort during RST_HOLD
        bus.enable = 1'b1;
        @(negedge clk);
        check_output("abort_hold_reach", 32'(bus.state), 32'd1);
        bus.enable = 1'b0;
        @(negedge clk);
        check_all_off("abort_hold");

        // Lock timeout: two 32-cycle windows then FAULT
        bus.pll_lock = 1'b0;
        repeat (8) @(negedge clk);
        bus.enable = 1'b1;
        repeat (36) @(negedge clk);
        check_output("tmo1_window_end", 32'({bus.state, bus.retry_cnt}), 32'({3'd2, 4'd0}));
        @(negedge clk);
        check_output("tmo1_retry", 32'({bus.state, bus.retry_cnt}), 32'({3'd1, 4'd1}));
        repeat (35) @(negedge clk);
        check_output("tmo2_window_end", 32'(bus.state), 32'd2);
        @(negedge clk);
        check_output("tmo2_fault_state", 32'(bus.state), 32'd5);
        check_output("tmo2_fault_outs",
                     32'({bus.fault, bus.pll_en, bus.pll_resetn, bus.clkout_en}), 32'b1000);
        check_output("tmo2_retry", 32'(bus.retry_cnt), 32'd2);
        repeat (3) @(negedge clk);
        check_output("fault_sticky", 32'(bus.fault), 32'd1);
        bus.enable = 1'b0;
        @(negedge clk);
        check_all_off("fault_clear");

        // Loss counter saturation
        bus.pll_lock = 1'b1;
        bus.enable   = 1'b1;
        wait_ready(1'b1, 80, "sat_start");
        check_output("sat_retry_clr", 32'(bus.retry_cnt), 32'd0);
        errs_before = error_count;
        for (int i = 0; i < 255; i++) begin
            bus.pll_lock = 1'b0;
            wait_ready(1'b0, 20, "sat_drop");
            bus.pll_lock = 1'b1;
            wait_ready(1'b1, 80, "sat_relock");
            if (error_count != errs_before) break;
        end
        check_output("sat_255", 32'(bus.loss_cnt), 32'd255);
        bus.pll_lock = 1'b0;
        wait_ready(1'b0, 20, "sat_drop_last");
        bus.pll_lock = 1'b1;
        wait_ready(1'b1, 80, "sat_relock_last");
        check_output("sat_hold", 32'(bus.loss_cnt), 32'd255);
        check_output("sat_run", 32'(bus.state), 32'd4);

        check_output("invariant", 32'(inv_errors), 32'd0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
